// File: rtl/a2d_arbiter.sv
// a2d_arbiter -- shares one A2D converter between two requesters.
//   Requester 0 is the line-sensor sequencer; requester 1 is housekeeping.
//   Round-robin grant, then SETTLE_CLKS of emitter/sensor settle time,
//   then a one-cycle strt_cnv pulse, then wait for cnv_cmplt. The result
//   is returned on res with a one-cycle vld pulse to the owner.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/chnnl0         requester 0 request (held until vld0) and channel
//   req1/chnnl1         requester 1 request (held until vld1) and channel
//   gnt0/gnt1           ownership of the converter
//   vld0/vld1           one-cycle result-valid pulse per requester
//   res                 last conversion result, held until next completion
//   busy                high whenever the arbiter is not idle
//   err                 one-cycle watchdog pulse (0 unless A2D_TIMEOUT_EN)
//   strt_cnv/chnnl      start pulse and channel to the A2D interface
//   cnv_cmplt/A2D_res   completion pulse and result from the A2D interface
//
// Build option: define A2D_TIMEOUT_EN to add a WAIT-state watchdog of
// TIMEOUT_CLKS cycles that completes the transaction with res=0 and err.
module a2d_arbiter #(
  parameter int SETTLE_CLKS  = 4096,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [2:0]  chnnl0,
  input  logic        req1,
  input  logic [2:0]  chnnl1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        vld0,
  output logic        vld1,
  output logic [11:0] res,
  output logic        busy,
  output logic        err,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;     // one-hot owner: bit0 = req0, bit1 = req1
  logic [1:0]  vld_q, vld_d;
  logic        last_q, last_d;   // index of the requester served last
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic [11:0] res_q, res_d;
  logic        strt_q, strt_d;
  logic        busy_q, busy_d;
  logic        pick1;            // IDLE grant goes to requester 1
  logic        req_own;          // request line of the current owner

  // On a tie the requester that was not served last wins.
  assign pick1   = (req0 & req1) ? ~last_q : req1;
  assign req_own = gnt_q[1] ? req1 : req0;

`ifdef A2D_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = 2'b00;
    last_d  = last_q;
    cnt_d   = cnt_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
    strt_d  = 1'b0;
`ifdef A2D_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // cnv_cmplt is deliberately not looked at here.
        if (req0 | req1) begin
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          chnnl_d = pick1 ? chnnl1 : chnnl0;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // An owner dropping its request wins over a due start pulse.
        if (!req_own) begin
          gnt_d   = 2'b00;
          last_d  = gnt_q[1];
          state_d = IDLE;
        end else if (cnt_q == 16'(SETTLE_CLKS - 1)) begin
          strt_d  = 1'b1;
          state_d = WAIT;
`ifdef A2D_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT: begin
        if (cnv_cmplt) begin
          res_d = A2D_res;
          if (req_own) begin
            vld_d   = gnt_q;
            state_d = DONE;
          end else begin
            // Owner walked away: keep the result, skip the valid pulse.
            gnt_d   = 2'b00;
            last_d  = gnt_q[1];
            state_d = IDLE;
          end
        end
`ifdef A2D_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CLKS - 1)) begin
          res_d   = 12'h000;
          vld_d   = gnt_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      vld_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      chnnl_q <= 3'b000;
      res_q   <= 12'h000;
      strt_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef A2D_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      strt_q  <= strt_d;
      busy_q  <= busy_d;
`ifdef A2D_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign vld0     = vld_q[0];
  assign vld1     = vld_q[1];
  assign res      = res_q;
  assign busy     = busy_q;
  assign strt_cnv = strt_q;
  assign chnnl    = chnnl_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// Self-checking bench for a2d_arbiter: directed scenarios plus a random
// transaction loop, with expectations from a transaction-level model
// (who was served last, expected result, expected channel, cycle offsets).
module tb_a2d_arbiter;
  localparam int SC = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, req0, req1, cnv_cmplt;
  logic [2:0]  chnnl0, chnnl1, chnnl;
  logic [11:0] A2D_res, res;
  logic        gnt0, gnt1, vld0, vld1, busy, err, strt_cnv;

  always #5 clk = ~clk;

  a2d_arbiter #(.SETTLE_CLKS(SC), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .chnnl0(chnnl0), .req1(req1),
    .chnnl1(chnnl1), .gnt0(gnt0), .gnt1(gnt1), .vld0(vld0), .vld1(vld1),
    .res(res), .busy(busy), .err(err), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int          last_srv = 1;
  logic [11:0] exp_res  = '0;
  logic [2:0]  exp_ch   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic int pick(input logic a, input logic b);
    if (a && b) return (last_srv == 0) ? 1 : 0;
    return b ? 1 : 0;
  endfunction

  task automatic drop(input int w);
    if (w == 1) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [1:0] g, input logic [1:0] v,
                           input logic s, input logic b, input logic e);
    chk({tag, ".gnt"},   32'({gnt1, gnt0}), 32'(g));
    chk({tag, ".vld"},   32'({vld1, vld0}), 32'(v));
    chk({tag, ".strt"},  32'(strt_cnv), 32'(s));
    chk({tag, ".busy"},  32'(busy), 32'(b));
    chk({tag, ".err"},   32'(err), 32'(e));
    chk({tag, ".res"},   32'(res), 32'(exp_res));
    chk({tag, ".chnnl"}, 32'(chnnl), 32'(exp_ch));
  endtask

  task automatic do_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cnv_cmplt = 1'b0;
    tick;
    last_srv = 1; exp_res = '0; exp_ch = '0;
    check_out("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Runs one transaction from an IDLE cycle with request(s) already set.
  // mode: 0 normal, 1 abort in settle cycle ab_at, 2 owner drops in WAIT,
  //       3 reset in WAIT, 4 watchdog timeout.
  task automatic serve(input int mode, input int dly, input int ab_at,
                       input logic stray, output int w);
    logic [2:0]  ch;
    logic [11:0] r;
    w  = pick(req0, req1);
    ch = (w == 1) ? chnnl1 : chnnl0;
    if (stray) begin cnv_cmplt = 1'b1; A2D_res = 12'($urandom); end
    tick;
    cnv_cmplt = 1'b0;
    exp_ch = ch;
    check_out("grant", onehot(w), 2'b00, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= SC; c++) begin
      if (mode == 1 && c == ab_at) begin
        drop(w);
        tick;
        last_srv = w;
        check_out("abort", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (stray && c == 2) begin cnv_cmplt = 1'b1; A2D_res = 12'($urandom); end
      tick;
      cnv_cmplt = 1'b0;
      check_out((c == SC) ? "strt" : "settle", onehot(w), 2'b00, c == SC, 1'b1, 1'b0);
    end
    if (mode == 3) begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      tick;
      rst = 1'b0;
      last_srv = 1; exp_res = '0; exp_ch = '0;
      check_out("rst_wait", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      cnv_cmplt = 1'b1; A2D_res = 12'($urandom);
      tick;
      cnv_cmplt = 1'b0;
      check_out("rst_cmplt", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      return;
    end
    if (mode == 4) begin
      for (int k = 1; k <= TO; k++) begin
        tick;
        if (k < TO) check_out("to_wait", onehot(w), 2'b00, 1'b0, 1'b1, 1'b0);
        else begin
          exp_res = '0;
          check_out("timeout", onehot(w), onehot(w), 1'b0, 1'b1, 1'b1);
        end
      end
      drop(w);
      tick;
      last_srv = w;
      check_out("to_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      return;
    end
    for (int k = 0; k < dly; k++) begin
      tick;
      check_out("wait", onehot(w), 2'b00, 1'b0, 1'b1, 1'b0);
    end
    if (mode == 2) begin
      drop(w);
      tick;
      check_out("late_wait", onehot(w), 2'b00, 1'b0, 1'b1, 1'b0);
    end
    r = 12'($urandom);
    cnv_cmplt = 1'b1; A2D_res = r;
    tick;
    cnv_cmplt = 1'b0;
    exp_res = r;
    if (mode == 2) begin
      last_srv = w;
      check_out("late", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      return;
    end
    check_out("done", onehot(w), onehot(w), 1'b0, 1'b1, 1'b0);
    drop(w);
    tick;
    last_srv = w;
    check_out("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) if (rst === 1'b0) chk("overlap", 32'(gnt0 & gnt1), 32'd0);

  initial begin
    int w;
    A2D_res = '0; chnnl0 = '0; chnnl1 = '0;
    do_reset;

    // single request: strt at cycle 9, cmplt at cycle 20
    req0 = 1'b1; chnnl0 = 3'd1;
    serve(0, 11, 0, 1'b0, w);
    chk("single.who", 32'(w), 32'd0);

    // tie after reset: strict alternation
    do_reset;
    req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'd4; chnnl1 = 3'd7;
    for (int i = 0; i < 4; i++) begin
      serve(0, 2, 0, 1'b0, w);
      chk("tie.who", 32'(w), 32'(i % 2));
      if (i < 3) begin if (w == 1) req1 = 1'b1; else req0 = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;

    // abort in settle, then a tie goes to requester 0
    req1 = 1'b1; chnnl1 = 3'd2;
    serve(1, 0, 3, 1'b0, w);
    tick;
    check_out("abort_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'd5; chnnl1 = 3'd6;
    serve(0, 1, 0, 1'b0, w);
    chk("abort_tie.who", 32'(w), 32'd0);
    serve(0, 0, 0, 1'b0, w);
    chk("abort_tie2.who", 32'(w), 32'd1);

    // stray completion in idle, then stray in grant/settle, then late drop
    cnv_cmplt = 1'b1; A2D_res = 12'hFFF;
    tick;
    cnv_cmplt = 1'b0;
    check_out("stray_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    req0 = 1'b1; chnnl0 = 3'd3;
    serve(0, 1, 0, 1'b1, w);
    req1 = 1'b1; chnnl1 = 3'd0;
    serve(2, 2, 0, 1'b0, w);

    // reset in WAIT
    req0 = 1'b1; chnnl0 = 3'd6;
    serve(3, 0, 0, 1'b0, w);

`ifdef A2D_TIMEOUT_EN
    req0 = 1'b1; chnnl0 = 3'd2;
    serve(4, 0, 0, 1'b0, w);
    req0 = 1'b1;
    serve(0, 3, 0, 1'b0, w);
`endif

    // random traffic
    for (int i = 0; i < 30; i++) begin
      int m;
      if (!req0 && !req1) begin
        case ($urandom_range(0, 2))
          0: begin req0 = 1'b1; chnnl0 = 3'($urandom); end
          1: begin req1 = 1'b1; chnnl1 = 3'($urandom); end
          default: begin
            req0 = 1'b1; chnnl0 = 3'($urandom);
            req1 = 1'b1; chnnl1 = 3'($urandom);
          end
        endcase
      end
      m = $urandom_range(0, 5);
      if (m > 2) m = 0;
      serve(m, $urandom_range(0, 5), $urandom_range(1, SC), 1'($urandom), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
